// File: rtl/toll_datapath.sv
// toll_datapath: responder side of the toll-gate control interface.
//
// Executes the controller's command strobes and returns the status it waits on.
// Three parts share this module:
//   - transit timer (init clears, count advances, saturates at all-ones)
//   - E-pass validation FSM with card-reader req/ack handshake and fee debit
//   - barrier motor FSM with an authorised-vehicle counter
//
// Optional feature macro: TOLL_SPEED_FEE_EN
//   defined   : fee is FEE_FAST when the transit time is below FAST_THRESH, else FEE_BASE
//   undefined : fee is always FEE_BASE (timer still runs)
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   init, count         transit timer clear / advance (init wins)
//   cal                 validation request level
//   up, dis             open request pulse / vehicle-passed pulse
//   manual_pay          cash override after a reject
//   card_ack            card reader acknowledge, card_balance valid with it
//   card_req            card read request
//   card_debit          one-cycle debit strobe, card_debit_amt valid with it
//   valid_Epass         00 idle/pending, 10 accepted, 01 rejected
//   enable              barrier fully open
//   done                one-cycle pulse when barrier reaches closed
//   num_veh             authorised vehicles not yet passed (0..3)
//   transit_time        current timer value
// All outputs are registered.

module toll_datapath #(
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned BAL_W       = 16,
    parameter int unsigned FEE_BASE    = 10,
    parameter int unsigned FEE_FAST    = 20,
    parameter int unsigned FAST_THRESH = 50,
    parameter int unsigned MOTOR_CYC   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              init,
    input  logic              count,
    input  logic              cal,
    input  logic              up,
    input  logic              dis,
    input  logic              manual_pay,
    input  logic              card_ack,
    input  logic [BAL_W-1:0]  card_balance,
    output logic              card_req,
    output logic              card_debit,
    output logic [BAL_W-1:0]  card_debit_amt,
    output logic [1:0]        valid_Epass,
    output logic              enable,
    output logic              done,
    output logic [1:0]        num_veh,
    output logic [TIME_W-1:0] transit_time
);

`ifdef TOLL_SPEED_FEE_EN
    localparam bit SpeedFeeEn = 1'b1;
`else
    localparam bit SpeedFeeEn = 1'b0;
`endif

    // Travel counter counts MOTOR_CYC-1 down to 0, so MOTOR_CYC cycles per move.
    localparam int unsigned CntW = (MOTOR_CYC > 1) ? $clog2(MOTOR_CYC) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MOTOR_CYC - 1);

    typedef enum logic [1:0] {
        StValIdle,
        StValReq,
        StValCheck,
        StValResult
    } val_state_e;

    typedef enum logic [1:0] {
        StClosed,
        StOpening,
        StOpen,
        StClosing
    } bar_state_e;

    val_state_e        val_q, val_d;
    bar_state_e        bar_q, bar_d;
    logic [TIME_W-1:0] transit_q, transit_d;
    logic [BAL_W-1:0]  bal_q, bal_d;
    logic              cal_prev_q;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [1:0]        num_veh_q, num_veh_d;

    logic              card_req_q, card_req_d;
    logic              card_debit_q, card_debit_d;
    logic [BAL_W-1:0]  amt_q, amt_d;
    logic [1:0]        valid_q, valid_d;
    logic              enable_q, enable_d;
    logic              done_q, done_d;

    logic [BAL_W-1:0]  fee;
    logic              grant;
    logic              open_req;

    // Transit timer
    always_comb begin
        transit_d = transit_q;
        if (init) begin
            transit_d = '0;
        end else if (count && (transit_q != {TIME_W{1'b1}})) begin
            transit_d = transit_q + TIME_W'(1);
        end
    end

    always_comb begin
        fee = BAL_W'(FEE_BASE);
        if (SpeedFeeEn && (transit_q < TIME_W'(FAST_THRESH))) begin
            fee = BAL_W'(FEE_FAST);
        end
    end

    // Validation FSM
    always_comb begin
        val_d        = val_q;
        bal_d        = bal_q;
        valid_d      = valid_q;
        card_debit_d = 1'b0;
        amt_d        = '0;
        grant        = 1'b0;
        unique case (val_q)
            StValIdle: begin
                valid_d = 2'b00;
                if (cal && !cal_prev_q) begin
                    val_d = StValReq;
                end
            end
            StValReq: begin
                if (!cal) begin
                    val_d = StValIdle;
                end else if (card_ack) begin
                    bal_d = card_balance;
                    val_d = StValCheck;
                end
            end
            StValCheck: begin
                if (!cal) begin
                    val_d = StValIdle;
                end else if (bal_q >= fee) begin
                    valid_d      = 2'b10;
                    card_debit_d = 1'b1;
                    amt_d        = fee;
                    grant        = 1'b1;
                    val_d        = StValResult;
                end else begin
                    valid_d = 2'b01;
                    val_d   = StValResult;
                end
            end
            StValResult: begin
                // Cash override only applies to a rejected card.
                if ((valid_q == 2'b01) && manual_pay) begin
                    grant = 1'b1;
                end
                if (!cal) begin
                    valid_d = 2'b00;
                    val_d   = StValIdle;
                end
            end
            default: begin
                val_d = StValIdle;
            end
        endcase
        card_req_d = (val_d == StValReq);
    end

    // Vehicle counter and barrier FSM
    always_comb begin
        open_req  = up | grant;
        num_veh_d = num_veh_q;
        // Simultaneous open request and dis cancel out.
        if (open_req && !dis) begin
            if (num_veh_q != 2'd3) begin
                num_veh_d = num_veh_q + 2'd1;
            end
        end else if (dis && !open_req) begin
            if (num_veh_q != 2'd0) begin
                num_veh_d = num_veh_q - 2'd1;
            end
        end

        bar_d = bar_q;
        cnt_d = cnt_q;
        unique case (bar_q)
            StClosed: begin
                if (open_req) begin
                    bar_d = StOpening;
                    cnt_d = CntLoad;
                end
            end
            StOpening: begin
                if (cnt_q == '0) begin
                    bar_d = StOpen;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StOpen: begin
                if (num_veh_d == 2'd0) begin
                    bar_d = StClosing;
                    cnt_d = CntLoad;
                end
            end
            StClosing: begin
                if (open_req) begin
                    bar_d = StOpening;
                    cnt_d = CntLoad;
                end else if (cnt_q == '0) begin
                    bar_d = StClosed;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                bar_d = StClosed;
            end
        endcase
        enable_d = (bar_d == StOpen);
        done_d   = (bar_q == StClosing) && (bar_d == StClosed);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            val_q        <= StValIdle;
            bar_q        <= StClosed;
            transit_q    <= '0;
            bal_q        <= '0;
            cal_prev_q   <= 1'b0;
            cnt_q        <= '0;
            num_veh_q    <= 2'd0;
            card_req_q   <= 1'b0;
            card_debit_q <= 1'b0;
            amt_q        <= '0;
            valid_q      <= 2'b00;
            enable_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            val_q        <= val_d;
            bar_q        <= bar_d;
            transit_q    <= transit_d;
            bal_q        <= bal_d;
            cal_prev_q   <= cal;
            cnt_q        <= cnt_d;
            num_veh_q    <= num_veh_d;
            card_req_q   <= card_req_d;
            card_debit_q <= card_debit_d;
            amt_q        <= amt_d;
            valid_q      <= valid_d;
            enable_q     <= enable_d;
            done_q       <= done_d;
        end
    end

    assign card_req       = card_req_q;
    assign card_debit     = card_debit_q;
    assign card_debit_amt = amt_q;
    assign valid_Epass    = valid_q;
    assign enable         = enable_q;
    assign done           = done_q;
    assign num_veh        = num_veh_q;
    assign transit_time   = transit_q;

endmodule
